dac_spi_tx: RTL and testbench

Serial DAC driver downstream of the waveform ROM: it takes the 8-bit DDS sample stream and ships one sample per frame to an external 16-bit-frame SPI DAC. Mode 0 (CPOL=0, CPHA=0), MSB first. It runs in the 48 MHz system clock domain and is the alternative to driving an R-2R ladder from the parallel sample bus. A continuously valid sample source is decimated to the SPI frame rate by sampling whatever is present at accept time.

---
 rtl/dac_spi_tx.sv | 193 +++++++++++++++++++
 tb/tb_dac_spi_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx
// ----------
// Serial DAC driver. Accepts one 8-bit sample per frame from the DDS sample
// stream and shifts the 16-bit word {CTRL_NIBBLE, sample, 4'b0000} out
// MSB first as SPI mode 0 (CPOL=0, CPHA=0). A continuously valid source is
// decimated to the frame rate because a sample is only taken at accept time.
//
// Parameters
//   CLK_DIV      system clocks per SCLK half-period (>=1)
//   CS_HIGH      minimum clocks cs_n stays high between frames (>=1)
//   CTRL_NIBBLE  constant placed in frame bits [15:12]
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           synchronous active-high reset
//   sample_i        DAC sample code
//   sample_valid_i  sample_i valid (may be tied high)
//   sample_ready_o  block accepts a sample this cycle
//   spi_cs_n_o      DAC chip select, active low
//   spi_sclk_o      SPI clock, idles low
//   spi_mosi_o      serial data, changes on SCLK falling edges
//   frame_done_o    one-cycle pulse after the last high phase of a frame
//   busy_o          high from accept until back in IDLE (= ~sample_ready_o)
//
// All outputs are registered.

module dac_spi_tx #(
  parameter int         CLK_DIV     = 2,
  parameter int         CS_HIGH     = 4,
  parameter logic [3:0] CTRL_NIBBLE = 4'h0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  output logic       sample_ready_o,
  output logic       spi_cs_n_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       frame_done_o,
  output logic       busy_o
);

  // One counter serves both the SCLK phase timing and the CS-high hold,
  // so it is sized for the larger of the two terminal counts.
  localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CS_LAST  = CNT_W'(CS_HIGH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       bit_q,   bit_d;     // completed high phases, 0..15
  logic [14:0]      shift_q, shift_d;   // bits still to send after the MSB
  logic             ready_q, ready_d;
  logic             cs_n_q,  cs_n_d;
  logic             sclk_q,  sclk_d;
  logic             mosi_q,  mosi_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;

  logic [15:0] word;
  logic        cnt_wrap;

  assign word     = {CTRL_NIBBLE, sample_i, 4'b0000};
  assign cnt_wrap = (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ready_d = ready_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_valid_i && ready_q) begin
          // The MSB goes straight onto the wire; the rest waits in shift_q.
          shift_d = word[14:0];
          mosi_d  = word[15];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = 4'd0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        // cs_n-to-first-rise setup time, one half-period.
        if (cnt_wrap) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SHIFT: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == 4'd15) begin
              // End of the 16th high phase: close the frame without a
              // further data update.
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              done_d  = 1'b1;
              state_d = HOLD;
            end else begin
              // Data changes on the falling edge so it is stable a full
              // half-period either side of the next rising edge.
              mosi_d  = shift_q[14];
              shift_d = {shift_q[13:0], 1'b0};
              bit_d   = bit_q + 4'd1;
            end
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HOLD: begin
        if (cnt_q == CS_LAST) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Abandons any frame in flight, including the latched word.
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= '0;
      ready_q <= 1'b1;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sample_ready_o = ready_q;
  assign spi_cs_n_o     = cs_n_q;
  assign spi_sclk_o     = sclk_q;
  assign spi_mosi_o     = mosi_q;
  assign frame_done_o   = done_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx. Unit 0 uses the default parameters, unit 1 the
// CLK_DIV=1 / CS_HIGH=1 / CTRL_NIBBLE=9 corner. A timeline model predicts
// every output from the cycle offset since the last accept.

module tb_dac_spi_tx;

  logic       clk = 1'b0;
  logic [1:0] rst   = 2'b11;
  logic [1:0] valid = 2'b00;
  logic [7:0] samp [2];
  logic [1:0] rdy, csn, sclk, mosi, done, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_spi_tx dut0 (
    .clk_i(clk), .rst_i(rst[0]), .sample_i(samp[0]), .sample_valid_i(valid[0]),
    .sample_ready_o(rdy[0]), .spi_cs_n_o(csn[0]), .spi_sclk_o(sclk[0]),
    .spi_mosi_o(mosi[0]), .frame_done_o(done[0]), .busy_o(busy[0])
  );

  dac_spi_tx #(.CLK_DIV(1), .CS_HIGH(1), .CTRL_NIBBLE(4'h9)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .sample_i(samp[1]), .sample_valid_i(valid[1]),
    .sample_ready_o(rdy[1]), .spi_cs_n_o(csn[1]), .spi_sclk_o(sclk[1]),
    .spi_mosi_o(mosi[1]), .frame_done_o(done[1]), .busy_o(busy[1])
  );

  function automatic int divof(input int u);
    return (u == 0) ? 2 : 1;
  endfunction
  function automatic int csof(input int u);
    return (u == 0) ? 4 : 1;
  endfunction
  function automatic logic [3:0] ctrlof(input int u);
    return (u == 0) ? 4'h0 : 4'h9;
  endfunction

  // Outputs r cycles after the accept edge, as {ready,cs_n,sclk,mosi,done,busy}.
  function automatic logic [5:0] model_out(input int r, input int d, input int ch,
                                           input logic [15:0] w);
    logic [5:0] o;
    o = 6'b110000;
    if (r < 32*d) begin
      o[5] = 1'b0;
      o[4] = 1'b0;
      o[3] = ((r / d) % 2) == 1;
      o[2] = w[15 - r/(2*d)];
      o[0] = 1'b1;
    end else if (r < 32*d + ch) begin
      o[5] = 1'b0;
      o[1] = (r == 32*d);
      o[0] = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  int          cyc = 0;
  logic        m_act [2] = '{1'b0, 1'b0};
  int          m_t0  [2] = '{0, 0};
  logic [15:0] m_word[2] = '{16'h0, 16'h0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < 2; u++) begin
      if (rst[u]) begin
        m_act[u] <= 1'b0;
      end else if ((!m_act[u] || (cyc - m_t0[u]) >= 32*divof(u) + csof(u)) && valid[u]) begin
        m_act[u]  <= 1'b1;
        m_t0[u]   <= cyc + 1;
        m_word[u] <= {ctrlof(u), samp[u], 4'h0};
      end
    end
  end

  // ---------------- compare + monitor ----------------
  logic        prev_cs  [2] = '{1'b1, 1'b1};
  logic        prev_sck [2] = '{1'b0, 1'b0};
  logic        prev_rdy [2] = '{1'b0, 1'b0};
  logic [15:0] cap      [2] = '{16'h0, 16'h0};
  logic [15:0] last_word[2] = '{16'h0, 16'h0};
  logic [15:0] prev_word[2] = '{16'h0, 16'h0};
  int fall_cyc [2] = '{0, 0};
  int last_fall[2] = '{-1, -1};
  int spacing  [2] = '{0, 0};
  int gap      [2] = '{0, 0};
  int rise_end [2] = '{0, 0};
  int low_len  [2] = '{0, 0};
  int rises    [2] = '{0, 0};
  int nrises   [2] = '{0, 0};
  int first_r  [2] = '{0, 0};
  int last_r   [2] = '{0, 0};
  int span     [2] = '{0, 0};
  int frames   [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int ready_cyc[2] = '{0, 0};

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [5:0] e;
      logic [5:0] g;
      e = m_act[u] ? model_out(cyc - m_t0[u], divof(u), csof(u), m_word[u]) : 6'b110000;
      g = {rdy[u], csn[u], sclk[u], mosi[u], done[u], busy[u]};
      chk(u == 0 ? "outputs_u0" : "outputs_u1", 32'(g), 32'(e));

      if (!csn[u] && prev_cs[u]) begin
        fall_cyc[u] <= cyc;
        cap[u]      <= 16'h0;
        rises[u]    <= 0;
        if (last_fall[u] >= 0) spacing[u] <= cyc - last_fall[u];
        last_fall[u] <= cyc;
        gap[u]       <= cyc - rise_end[u];
      end
      if (sclk[u] && !prev_sck[u]) begin
        cap[u]   <= {cap[u][14:0], mosi[u]};
        rises[u] <= rises[u] + 1;
        if (rises[u] == 0) first_r[u] <= cyc;
        last_r[u] <= cyc;
      end
      if (csn[u] && !prev_cs[u]) begin
        rise_end[u] <= cyc;
        low_len[u]  <= cyc - fall_cyc[u];
        nrises[u]   <= rises[u];
        span[u]     <= last_r[u] - first_r[u];
        if (rises[u] == 16) begin
          prev_word[u] <= last_word[u];
          last_word[u] <= cap[u];
          frames[u]    <= frames[u] + 1;
        end
        if (m_act[u] && (cyc - m_t0[u]) == 32*divof(u))
          chk(u == 0 ? "frame_word_u0" : "frame_word_u1", 32'(cap[u]), 32'(m_word[u]));
      end
      if (done[u]) begin
        done_cnt[u] <= done_cnt[u] + 1;
        done_cyc[u] <= cyc;
      end
      if (rdy[u] && !prev_rdy[u]) ready_cyc[u] <= cyc;
      prev_cs[u]  <= csn[u];
      prev_sck[u] <= sclk[u];
      prev_rdy[u] <= rdy[u];
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_frames(input int u, input int tgt);
    int n;
    n = 0;
    while (frames[u] < tgt && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (frames[u] < tgt) begin
      checks++;
      errors++;
      $display("FAIL wait_frames_u%0d: got %0d frames, expected %0d", u, frames[u], tgt);
    end
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    while (rdy[u] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rdy[u] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready_u%0d: got ready %b, expected 1", u, rdy[u]);
    end
  endtask

  initial begin
    int tgt;
    int saved;
    samp[0] = 8'h00;
    samp[1] = 8'h00;

    // Literal pins on the model itself.
    chk("model_r0",  32'(model_out(0,  2, 4, 16'h0A50)), 32'h01);
    chk("model_r2",  32'(model_out(2,  2, 4, 16'h8000)), 32'h0D);
    chk("model_r64", 32'(model_out(64, 2, 4, 16'hFFFF)), 32'h13);
    chk("model_r68", 32'(model_out(68, 2, 4, 16'hFFFF)), 32'h30);

    // Reset with valid high.
    valid = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_outputs_u0", 32'({rdy[0], csn[0], sclk[0], mosi[0], done[0], busy[0]}), 32'h30);
    rst = 2'b00;
    valid = 2'b00;
    @(negedge clk);

    // Single frame, defaults.
    wait_ready(0);
    tgt = frames[0] + 1;
    valid[0] = 1'b1; samp[0] = 8'hA5;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_frames(0, tgt);
    wait_ready(0);
    @(negedge clk);
    chk("single_word",    32'(last_word[0]), 32'h0A50);
    chk("single_cs_low",  32'(low_len[0]), 64);
    chk("single_rises",   32'(nrises[0]), 16);
    chk("single_span",    32'(span[0]), 60);
    chk("single_done_at", 32'(done_cyc[0] - fall_cyc[0]), 64);
    chk("single_rdy_at",  32'(ready_cyc[0] - fall_cyc[0]), 68);

    // Continuous stream.
    tgt = frames[0] + 2;
    valid[0] = 1'b1; samp[0] = 8'h00;
    @(negedge clk);
    samp[0] = 8'hFF;
    wait_frames(0, tgt);
    valid[0] = 1'b0;
    chk("stream_word1",   32'(prev_word[0]), 32'h0000);
    chk("stream_word2",   32'(last_word[0]), 32'h0FF0);
    chk("stream_spacing", 32'(spacing[0]), 69);
    chk("stream_cs_gap",  32'(gap[0]), 5);

    // Mid-frame data change.
    wait_ready(0);
    tgt = frames[0] + 1;
    valid[0] = 1'b1; samp[0] = 8'h3C;
    @(negedge clk);
    samp[0] = 8'hC3;
    for (int i = 0; i < 40; i++) begin
      valid[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    valid[0] = 1'b0;
    wait_frames(0, tgt);
    chk("midchange_word", 32'(last_word[0]), 32'h03C0);

    // Reset mid-frame at t0+20.
    wait_ready(0);
    @(negedge clk);
    valid[0] = 1'b1; samp[0] = 8'h77;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (19) @(negedge clk);
    rst[0] = 1'b1;
    saved = done_cnt[0];
    @(negedge clk);
    chk("rst_mid_outputs", 32'({rdy[0], csn[0], sclk[0], mosi[0]}), 32'hC);
    rst[0] = 1'b0;
    tgt = frames[0] + 1;
    valid[0] = 1'b1; samp[0] = 8'h55;
    @(negedge clk);
    chk("rst_reaccept_busy", 32'(busy[0]), 1);
    valid[0] = 1'b0;
    wait_frames(0, tgt);
    @(negedge clk);
    chk("rst_no_done", 32'(done_cnt[0]), 32'(saved + 1));
    chk("rst_next_word", 32'(last_word[0]), 32'h0550);

    // Parameter corner on unit 1.
    wait_ready(1);
    tgt = frames[1] + 2;
    valid[1] = 1'b1; samp[1] = 8'h81;
    wait_frames(1, tgt);
    valid[1] = 1'b0;
    chk("corner_word",    32'(last_word[1]), 32'h9810);
    chk("corner_cs_low",  32'(low_len[1]), 32);
    chk("corner_rises",   32'(nrises[1]), 16);
    chk("corner_span",    32'(span[1]), 30);
    chk("corner_spacing", 32'(spacing[1]), 34);

    // Random traffic on both units, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        valid[u] = ($urandom_range(0, 3) == 0);
        samp[u]  = 8'($urandom);
        rst[u]   = ($urandom_range(0, 599) == 0);
      end
    end
    valid = 2'b00;
    rst   = 2'b00;
    repeat (100) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
